pcihellocore_keyinput: RTL and testbench

Avalon-MM slave input port, the read-direction counterpart of the hex-display output PIO. Samples board pushbuttons/switches (`in_port`) and exposes them to the PCIe host through the same interconnect.
- Pipeline: metastability synchronisation, per-bit debounce, edge capture and a maskable level interrupt.
- Host polls DATA or services `irq`, then clears EDGECAP.

---
 rtl/pcihellocore_pio_pkg.sv | 21 ++
 rtl/pcihellocore_debounce_bit.sv | 57 +++++
 rtl/pcihellocore_keyinput.sv | 96 +++++++++
 tb/tb_pcihellocore_keyinput.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcihellocore_pio_pkg.sv
// Shared definitions for the pcihellocore PIO blocks: register addresses,
// edge-capture mode encodings and a debounce counter width helper.
package pcihellocore_pio_pkg;

    // Word addresses of the PIO register map
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge capture modes
    localparam int EDGE_ANY  = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;

    // Width of a counter that must hold values 0..cycles without wrapping
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pcihellocore_debounce_bit.sv
// One input bit: metastability synchroniser followed by a debounce counter.
// 'flip' is high during the cycle whose rising edge updates 'deb', so the
// parent can record the edge on that same clock edge. 'level' is the
// synchronised value, i.e. the value 'deb' takes when 'flip' is high.
module pcihellocore_debounce_bit
    import pcihellocore_pio_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic deb,
    output logic flip,
    output logic level
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    logic                   deb_reg;
    logic [CW-1:0]          cnt_reg;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign flip   = (synced != deb_reg) && (cnt_reg == CNT_LAST);
    assign deb    = deb_reg;
    assign level  = synced;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive cycles of disagreement; accept the new level once it persisted long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_reg <= RESET_BIT;
            cnt_reg <= '0;
        end else if (synced == deb_reg) begin
            cnt_reg <= '0;
        end else if (flip) begin
            deb_reg <= synced;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/pcihellocore_keyinput.sv
// Avalon-MM input PIO: debounced pushbutton/switch state, edge capture
// with write-1-to-clear, per-bit interrupt mask and a level interrupt.
module pcihellocore_keyinput
    import pcihellocore_pio_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = EDGE_ANY,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] deb_bus;
    logic [WIDTH-1:0] flip_bus;
    logic [WIDTH-1:0] level_bus;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] clear_mask;
    logic             wr_en;
    logic             unused_wdata;

    // Upper write-data bits beyond WIDTH carry no meaning
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect && !write_n;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pcihellocore_debounce_bit #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_BIT      (RESET_VALUE[gi])
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (in_port[gi]),
                .deb    (deb_bus[gi]),
                .flip   (flip_bus[gi]),
                .level  (level_bus[gi])
            );

            // Qualify each accepted flip by the configured edge direction
            if (EDGE_MODE == EDGE_RISE) begin : g_rise
                assign cap_set[gi] = flip_bus[gi] & level_bus[gi];
            end else if (EDGE_MODE == EDGE_FALL) begin : g_fall
                assign cap_set[gi] = flip_bus[gi] & ~level_bus[gi];
            end else begin : g_any
                assign cap_set[gi] = flip_bus[gi];
            end
        end
    endgenerate

    // Write-1-to-clear mask; a fresh capture on the same edge overrides the clear
    assign clear_mask   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign edgecap_next = (edgecap_reg & ~clear_mask) | cap_set;

    // Host-visible mask and capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_reg <= '0;
            edgecap_reg <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask_reg <= writedata[WIDTH-1:0];
            end
            edgecap_reg <= edgecap_next;
        end
    end

    // Zero-wait-state read mux, zero-extended to the bus width
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = deb_bus;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_pcihellocore_keyinput.sv
// Testbench for pcihellocore_keyinput: two instances (any-edge and
// rising-edge capture) share the bus; each has its own input pins.
module tb_pcihellocore_keyinput;

    localparam int             W  = 4;
    localparam int             SS = 2;
    localparam int             D  = 4;
    localparam int             HL = SS + D;
    localparam logic [W-1:0]   RV = 4'hF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata0, readdata1;
    logic [W-1:0] in0 = RV;
    logic [W-1:0] in1 = RV;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcihellocore_keyinput #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .RESET_VALUE(RV)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0),
        .in_port(in0), .irq(irq0)
    );

    pcihellocore_keyinput #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .RESET_VALUE(RV)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1),
        .in_port(in1), .irq(irq1)
    );

    // Reference model: a level is accepted once the last D synchronised samples
    // all disagree with the accepted state; samples are the pin history delayed by SS.
    logic [W-1:0] m_samp [2][HL];
    logic [W-1:0] m_deb  [2];
    logic [W-1:0] m_cap  [2];
    logic [W-1:0] m_mask [2];

    function automatic logic [W-1:0] model_flips(input int n);
        logic [W-1:0] r;
        r = '1;
        for (int j = SS - 1; j < SS + D - 1; j++) r = r & (m_samp[n][j] ^ m_deb[n]);
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input int n, input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v[W-1:0] = m_deb[n];
            2'd2: v[W-1:0] = m_mask[n];
            2'd3: v[W-1:0] = m_cap[n];
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 2; n++) begin
                for (int j = 0; j < HL; j++) m_samp[n][j] <= RV;
                m_deb[n]  <= RV;
                m_cap[n]  <= '0;
                m_mask[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                m_samp[n][0] <= (n == 0) ? in0 : in1;
                for (int j = 1; j < HL; j++) m_samp[n][j] <= m_samp[n][j-1];
                m_deb[n] <= m_deb[n] ^ model_flips(n);
                m_cap[n] <= (m_cap[n] & ~((chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0))
                            | ((n == 0) ? model_flips(n) : (model_flips(n) & ~m_deb[n]));
                if (chipselect && !write_n && address == 2'd2) m_mask[n] <= writedata[W-1:0];
            end
        end
    end

    task automatic wait_edges(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v0, output logic [31:0] v1);
        address = a;
        #1;
        v0 = readdata0;
        v1 = readdata1;
        $display("[%0t] rd addr=%0d dut0=%h dut1=%h", $time, a, v0, v1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        $display("[%0t] wr addr=%0d data=%h", $time, a, d);
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r0, r1;
        logic [31:0] expv [4];
        expv = '{32'h0000000F, 32'h0, 32'h0, 32'h0};
        reset_n = 1'b0;
        in0 = RV;
        in1 = RV;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r0, r1);
            checks++;
            if (r0 !== expv[a]) begin
                errors++;
                $display("FAIL reset_read dut0 addr%0d: got %h expected %h", a, r0, expv[a]);
            end
            checks++;
            if (r1 !== expv[a]) begin
                errors++;
                $display("FAIL reset_read dut1 addr%0d: got %h expected %h", a, r1, expv[a]);
            end
        end
        checks++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b/%b expected 0/0", irq0, irq1);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] r0, r1, e;
        in0[0] = 1'b0;
        for (int k = 1; k <= SS + D; k++) begin
            wait_edges(1);
            rd(2'd0, r0, r1);
            e = (k < SS + D) ? 32'hF : 32'hE;
            checks++;
            if (r0 !== e) begin
                errors++;
                $display("FAIL debounce_data edge%0d: got %h expected %h", k, r0, e);
            end
        end
        rd(2'd3, r0, r1);
        checks++;
        if (r0 !== 32'h1) begin
            errors++;
            $display("FAIL debounce_edgecap: got %h expected 00000001", r0);
        end
        in0[0] = 1'b1;
        wait_edges(SS + D);
        wr(2'd3, 32'h1);
        rd(2'd3, r0, r1);
        checks++;
        if (r0 !== 32'h0) begin
            errors++;
            $display("FAIL debounce_clear: got %h expected 00000000", r0);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] r0, r1, c0, c1;
        in0[1] = 1'b0;
        wait_edges(D - 1);
        in0[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_edges(1);
            rd(2'd0, r0, r1);
            rd(2'd3, c0, c1);
            checks++;
            if (r0 !== 32'hF || c0 !== 32'h0) begin
                errors++;
                $display("FAIL glitch cycle%0d: got data=%h cap=%h expected data=0000000f cap=00000000", k, r0, c0);
            end
        end
        // A full-length step afterwards must still need the complete delay
        in0[1] = 1'b0;
        wait_edges(SS + D - 1);
        rd(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'hF) begin
            errors++;
            $display("FAIL glitch_step_early: got %h expected 0000000f", r0);
        end
        wait_edges(1);
        rd(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'hD) begin
            errors++;
            $display("FAIL glitch_step: got %h expected 0000000d", r0);
        end
        in0[1] = 1'b1;
        wait_edges(SS + D);
        wr(2'd3, 32'h2);
    endtask

    task automatic test_irq();
        logic [31:0] r0, r1;
        wr(2'd2, 32'h1);
        in0[0] = 1'b0;
        wait_edges(SS + D - 1);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b expected 0", irq0);
        end
        wait_edges(1);
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL irq_assert: got %b expected 1", irq0);
        end
        wr(2'd3, 32'h1);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c: got %b expected 0", irq0);
        end
        wr(2'd0, 32'h0);
        rd(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'hE) begin
            errors++;
            $display("FAIL data_write_ignored: got %h expected 0000000e", r0);
        end
        in0[0] = 1'b1;
        wait_edges(SS + D);
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise_assert: got %b expected 1", irq0);
        end
        wr(2'd2, 32'h0);
        rd(2'd3, r0, r1);
        checks++;
        if (irq0 !== 1'b0 || r0 !== 32'h1) begin
            errors++;
            $display("FAIL irq_mask_off: got irq=%b cap=%h expected irq=0 cap=00000001", irq0, r0);
        end
        wr(2'd3, 32'hF);
    endtask

    task automatic test_w1c_same_edge();
        logic [31:0] r0, r1;
        in0[3] = 1'b0;
        wait_edges(SS + D);
        rd(2'd3, r0, r1);
        checks++;
        if (r0 !== 32'h8) begin
            errors++;
            $display("FAIL w1c_setup: got %h expected 00000008", r0);
        end
        in0[2] = 1'b0;
        wait_edges(SS + D - 1);
        wr(2'd3, 32'hC);
        rd(2'd3, r0, r1);
        checks++;
        if (r0 !== 32'h4) begin
            errors++;
            $display("FAIL w1c_same_edge: got %h expected 00000004", r0);
        end
        rd(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h3) begin
            errors++;
            $display("FAIL w1c_data: got %h expected 00000003", r0);
        end
        in0 = RV;
        wait_edges(SS + D);
        wr(2'd3, 32'hF);
    endtask

    task automatic test_edge_mode_reset();
        logic [31:0] r0, r1, c0, c1, m0, m1;
        in0[0] = 1'b0;
        in1[0] = 1'b0;
        wait_edges(SS + D);
        rd(2'd0, r0, r1);
        rd(2'd3, c0, c1);
        checks++;
        if (r1 !== 32'hE || c1 !== 32'h0) begin
            errors++;
            $display("FAIL rise_mode_fall: got data=%h cap=%h expected data=0000000e cap=00000000", r1, c1);
        end
        checks++;
        if (c0 !== 32'h1) begin
            errors++;
            $display("FAIL any_mode_fall: got %h expected 00000001", c0);
        end
        in1[0] = 1'b1;
        wait_edges(SS + D);
        rd(2'd3, c0, c1);
        checks++;
        if (c1 !== 32'h1) begin
            errors++;
            $display("FAIL rise_mode_rise: got %h expected 00000001", c1);
        end
        wr(2'd2, 32'hF);
        checks++;
        if (irq0 !== 1'b1 || irq1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_irq: got %b/%b expected 1/1", irq0, irq1);
        end
        in1[1] = 1'b0;
        wait_edges(SS + 2);
        reset_n = 1'b0;
        #1;
        rd(2'd0, r0, r1);
        rd(2'd2, m0, m1);
        rd(2'd3, c0, c1);
        checks++;
        if (r0 !== 32'hF || r1 !== 32'hF || m0 !== 32'h0 || m1 !== 32'h0 || c0 !== 32'h0 || c1 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_regs: got data=%h/%h mask=%h/%h cap=%h/%h expected f/f 0/0 0/0",
                     r0, r1, m0, m1, c0, c1);
        end
        checks++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_irq: got %b/%b expected 0/0", irq0, irq1);
        end
        in0 = 4'hE;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_edges(SS + D - 1);
        rd(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'hF || r1 !== 32'hF) begin
            errors++;
            $display("FAIL post_reset_early: got %h/%h expected 0000000f/0000000f", r0, r1);
        end
        wait_edges(1);
        rd(2'd0, r0, r1);
        rd(2'd3, c0, c1);
        checks++;
        if (r0 !== 32'hE || c0 !== 32'h1 || r1 !== 32'hD || c1 !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_accept: got data=%h/%h cap=%h/%h expected e/d 1/0", r0, r1, c0, c1);
        end
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic [31:0] d;
        logic        do_wr;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) in0 = in0 ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 7) == 0) in1 = in1 ^ (W'(1) << $urandom_range(0, W - 1));
            do_wr = ($urandom_range(0, 5) == 0);
            a     = 2'($urandom_range(0, 3));
            d     = $urandom;
            address    = a;
            writedata  = d;
            chipselect = do_wr;
            write_n    = !do_wr;
            #1;
            $display("[%0t] rand %s addr=%0d data=%h rd0=%h rd1=%h irq=%b%b",
                     $time, do_wr ? "wr" : "rd", a, d, readdata0, readdata1, irq0, irq1);
            checks++;
            if (readdata0 !== exp_rd(0, a) || readdata1 !== exp_rd(1, a)) begin
                errors++;
                $display("FAIL random_read cycle%0d addr%0d: got %h/%h expected %h/%h",
                         k, a, readdata0, readdata1, exp_rd(0, a), exp_rd(1, a));
            end
            checks++;
            if (irq0 !== |(m_cap[0] & m_mask[0]) || irq1 !== |(m_cap[1] & m_mask[1])) begin
                errors++;
                $display("FAIL random_irq cycle%0d: got %b/%b expected %b/%b", k, irq0, irq1,
                         |(m_cap[0] & m_mask[0]), |(m_cap[1] & m_mask[1]));
            end
            @(posedge clk);
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_irq();
        test_w1c_same_edge();
        test_edge_mode_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
